sram_rmw_ctrl: RTL and testbench
================================

Name: sram_rmw_ctrl

Overview:
Request/response front-end that sits directly upstream of the single-port 8192x32 SRAM macro and drives its MEN/WEN/REN/ADDR/DIN pins. It consumes a valid/ready request stream that carries per-byte write enables. Because the macro has no byte mask, partial writes are executed as an internal read-modify-write. Read data is registered and returned on a valid/ready response channel.

Parameters:
AW, 13, address width; must match the macro address width.
DW, 32, data width; must be a multiple of 8.
BW, DW/8, byte-enable width (derived; not to be overridden).
DLY_VAL, 1'b1, constant value driven on sram_dly_o.

Ports:
clk_i  in  1  clock; all state updates on rising edge; also the macro clock.
rst_i  in  1  asynchronous, active-high reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at a rising edge.
req_we_i  in  1  1 = write, 0 = read.
req_addr_i  in  AW  word address.
req_wdata_i  in  DW  write data.
req_be_i  in  BW  byte enables; bit i covers wdata[8i+7:8i]; ignored for reads.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i at a rising edge.
rsp_rdata_o  out  DW  read data for reads; 0 for writes.
sram_men_o  out  1  to macro A_MEN.
sram_wen_o  out  1  to macro A_WEN.
sram_ren_o  out  1  to macro A_REN.
sram_addr_o  out  AW  to macro A_ADDR.
sram_din_o  out  DW  to macro A_DIN.
sram_dly_o  out  1  to macro A_DLY; constant DLY_VAL.
sram_dout_i  in  DW  from macro A_DOUT; valid in the cycle after a read edge.

Behaviour:
- Reset (async, rst_i=1):
  - State = IDLE.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0.
  - sram_men/wen/ren=0, sram_addr=0, sram_din=0.
  - All holding registers (addr_q, wdata_q, be_q) = 0.
- FSM states are IDLE, RD, MERGE, RSP. Only one request is in flight at a time.
- Macro pin driving:
  - In IDLE the macro pins are driven combinationally from the request fields, so the macro samples them on the acceptance edge.
  - In MERGE the pins are driven from the holding registers.
  - In all other cases men/wen/ren=0, while addr and din hold their last values.
- IDLE:
  - req_ready_o=1.
  - If req_valid_i=0, men/wen/ren=0.
  - On acceptance:
    - Read: men=1, ren=1, addr=req_addr_i. Next state RD.
    - Write with be all-ones: men=1, wen=1, addr, din=req_wdata_i. Next state RSP; rsp_rdata_q<=0.
    - Write with be=0: no macro access (men=0). Next state RSP; rsp_rdata_q<=0.
    - Partial write: men=1, ren=1, addr=req_addr_i. Latch addr_q, wdata_q, be_q. Next state MERGE.
- RD:
  - req_ready_o=0, macro idle.
  - rsp_rdata_q<=sram_dout_i. Next state RSP.
- MERGE:
  - req_ready_o=0. Drive men=1, wen=1, addr=addr_q.
  - din byte i = be_q[i] ? wdata_q byte i : sram_dout_i byte i.
  - rsp_rdata_q<=0. Next state RSP.
- RSP:
  - rsp_valid_o=1, req_ready_o=0.
  - rsp_rdata_o is held stable until rsp_ready_i.
  - On handshake, next state IDLE.
  - A new request is not accepted in the handshake cycle.
- Latency (acceptance edge N to first cycle with rsp_valid_o=1):
  - Reads and partial writes: edge N+2.
  - Full writes and be=0 writes: edge N+1.
- Throughput with rsp_ready_i tied high:
  - Reads and partial writes: one request per 3 cycles.
  - Full writes and be=0 writes: one request per 2 cycles.
- Response order equals request order, because only one transaction is outstanding.
- Request fields are sampled only at the acceptance edge. Changes to req_* while req_ready_o=0 have no effect.
- Reset mid-operation:
  - The FSM aborts immediately and any pending response is dropped.
  - Reset asserted before the MERGE edge: the partial write is not performed and the memory word is unchanged.
  - Reset during RSP: the write has already completed.
- At the maximum address (all-ones) there is no special casing and no wrap arithmetic.
- Macro setup/hold is met by construction: pins change only in the cycle after a rising edge.

Test Plan:
- Full write then read: write addr 0x0005, data 0xDEADBEEF, be 0xF → rsp_valid 1 cycle after accept with rdata 0. Read 0x0005 → rsp_valid 2 cycles after accept with rdata 0xDEADBEEF.
- Partial write RMW: preload 0x1FFF=0x11223344, write data 0xAABBCCDD with be 0x5 → MERGE drives din 0x11BB33DD. A subsequent read returns 0x11BB33DD.
- be=0 write: preload 0x0010=0x12345678, write data 0xFFFFFFFF with be 0x0 → men stays 0, response is returned, and a read of 0x0010 still gives 0x12345678.
- Response backpressure: read with rsp_ready_i low for 5 cycles → rsp_valid and rdata stay stable, req_ready 0, men 0. Raise rsp_ready → IDLE next cycle.
- Reset mid-RMW: preload 0x0020=0xCAFEF00D, partial write data 0x00000000 with be 0x1, assert rst_i during MERGE before the edge → all outputs go to 0 asynchronously. After release, a read of 0x0020 returns 0xCAFEF00D.
- Back-to-back stream: 16 random mixed reads, full writes and partial writes with rsp_ready random → responses in order, data matches a byte-masked scoreboard, and no macro access occurs while in RSP.

Source files
------------

// File: rtl/sram_rmw_ctrl.sv
// Front-end for a single-port SRAM macro without a byte mask. Requests are
// handled one at a time, and partial writes become a read followed by a merged write.
module sram_rmw_ctrl #(
  parameter int   AW      = 13,
  parameter int   DW      = 32,
  parameter logic DLY_VAL = 1'b1,
  localparam int  BW      = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [BW-1:0] req_be_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          sram_men_o,
  output logic          sram_wen_o,
  output logic          sram_ren_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_din_o,
  output logic          sram_dly_o,
  input  logic [DW-1:0] sram_dout_i
);

  typedef enum logic [1:0] {IDLE, RD, MERGE, RSP} state_t;

  state_t          state_q;
  logic            ready_q;
  logic            valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [AW-1:0]   addr_last_q;
  logic [DW-1:0]   din_last_q;
  logic [DW-1:0]   merge_data;
  logic            accept;
  logic            be_full;
  logic            be_none;

  assign accept  = req_valid_i && ready_q;
  assign be_full = &req_be_i;
  assign be_none = ~|req_be_i;

  // Old bytes come straight from the macro output in the cycle after the read edge.
  for (genvar gi = 0; gi < BW; gi++) begin : g_merge
    assign merge_data[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : sram_dout_i[8*gi +: 8];
  end

  always_comb begin
    sram_men_o  = 1'b0;
    sram_wen_o  = 1'b0;
    sram_ren_o  = 1'b0;
    sram_addr_o = addr_last_q;
    sram_din_o  = din_last_q;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (!req_we_i || !be_full) begin
              if (!req_we_i || !be_none) begin
                sram_men_o  = 1'b1;
                sram_ren_o  = 1'b1;
                sram_addr_o = req_addr_i;
              end
            end else begin
              sram_men_o  = 1'b1;
              sram_wen_o  = 1'b1;
              sram_addr_o = req_addr_i;
              sram_din_o  = req_wdata_i;
            end
          end
        end
        MERGE: begin
          sram_men_o  = 1'b1;
          sram_wen_o  = 1'b1;
          sram_addr_o = addr_q;
          sram_din_o  = merge_data;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign sram_dly_o  = DLY_VAL;

  // Address and data pins hold their last driven value while the macro is idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_last_q <= '0;
      din_last_q  <= '0;
    end else begin
      addr_last_q <= sram_addr_o;
      din_last_q  <= sram_din_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (!req_we_i) begin
              state_q <= RD;
            end else if (be_full || be_none) begin
              state_q     <= RSP;
              valid_q     <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= MERGE;
              addr_q  <= req_addr_i;
              wdata_q <= req_wdata_i;
              be_q    <= req_be_i;
            end
          end
        end
        RD: begin
          rsp_rdata_q <= sram_dout_i;
          valid_q     <= 1'b1;
          state_q     <= RSP;
        end
        MERGE: begin
          rsp_rdata_q <= '0;
          valid_q     <= 1'b1;
          state_q     <= RSP;
        end
        RSP: begin
          if (rsp_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Directed bench for sram_rmw_ctrl with a behavioural 8192x32 macro model
// and an independent byte-masked reference memory.
module tb_sram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [12:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        sram_men_o, sram_wen_o, sram_ren_o, sram_dly_o;
  logic [12:0] sram_addr_o;
  logic [31:0] sram_din_o;
  logic [31:0] sram_dout_i = '0;

  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int bad_acc = 0;

  logic [31:0] mem [0:8191];
  logic [31:0] ref_mem [0:8191];

  always #5 clk = ~clk;

  sram_rmw_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_men_o(sram_men_o), .sram_wen_o(sram_wen_o), .sram_ren_o(sram_ren_o),
    .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dly_o(sram_dly_o),
    .sram_dout_i(sram_dout_i)
  );

  always @(posedge clk) begin
    if (sram_men_o && sram_wen_o) mem[sram_addr_o] <= sram_din_o;
    if (sram_men_o && sram_ren_o) sram_dout_i <= mem[sram_addr_o];
    if (sram_men_o) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (rsp_valid_o && sram_men_o) bad_acc <= bad_acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present a request at a falling edge and return just after its acceptance edge.
  task automatic issue(input logic we, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_be_i    = be;
    n = 0;
    while (!req_ready_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) check("req_ready_timeout", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_wdata_i = 32'h5A5A5A5A;
    req_be_i    = 4'hF;
  endtask

  // Wait for the response, check latency (in falling edges after acceptance) and data, then handshake.
  task automatic get_rsp(input string tag, input logic [31:0] exp, input int exp_lat, input bit rand_rdy);
    int n;
    bit hs;
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, rsp_rdata_o, exp);
    n = 0;
    do begin
      rsp_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      hs = rsp_ready_i;
      #1;
      n++;
    end while (!hs && n < 50);
    rsp_ready_i = 1'b1;
  endtask

  task automatic do_write(input string tag, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    issue(1'b1, a, d, be);
    get_rsp(tag, 32'h0, (be == 4'hF || be == 4'h0) ? 0 : 1, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [12:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'h0, 4'h0);
    get_rsp(tag, exp, 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    logic [31:0] snap;
    logic [31:0] exp_d;
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int kind;

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    rsp_ready_i = 1'b1;
    #3;
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_men_wen_ren", {29'd0, sram_men_o, sram_wen_o, sram_ren_o}, 32'd0);
    check("rst_addr", {19'd0, sram_addr_o}, 32'd0);
    check("rst_din", sram_din_o, 32'd0);
    check("dly", {31'd0, sram_dly_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Full write then read
    do_write("full_wr", 13'h0005, 32'hDEADBEEF, 4'hF);
    do_read("rd_0005", 13'h0005, 32'hDEADBEEF);

    // Partial write read-modify-write at the top address
    do_write("preload_1fff", 13'h1FFF, 32'h11223344, 4'hF);
    issue(1'b1, 13'h1FFF, 32'hAABBCCDD, 4'h5);
    @(negedge clk);
    check("merge_wen", {30'd0, sram_men_o, sram_wen_o}, 32'd3);
    check("merge_addr", {19'd0, sram_addr_o}, 32'h1FFF);
    check("merge_din", sram_din_o, 32'h11BB33DD);
    get_rsp("part_wr", 32'h0, 0, 1'b0);
    do_read("rd_1fff", 13'h1FFF, 32'h11BB33DD);

    // be=0 write must not touch the macro
    do_write("preload_0010", 13'h0010, 32'h12345678, 4'hF);
    a0 = acc_cnt;
    do_write("be0_wr", 13'h0010, 32'hFFFFFFFF, 4'h0);
    check("be0_no_access", acc_cnt - a0, 0);
    do_read("rd_0010", 13'h0010, 32'h12345678);

    // Response backpressure
    rsp_ready_i = 1'b0;
    issue(1'b0, 13'h0005, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
    snap = rsp_rdata_o;
    check("bp_data", snap, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_rdata_o[31:3], rsp_valid_o, req_ready_o, sram_men_o}, {snap[31:3], 3'b100});
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, rsp_valid_o, req_ready_o}, 32'd1);

    // Reset before the merge edge leaves memory intact
    do_write("preload_0020", 13'h0020, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 13'h0020, 32'h00000000, 4'h1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_outs", {25'd0, req_ready_o, rsp_valid_o, sram_men_o, sram_wen_o, sram_ren_o, |sram_addr_o, |sram_din_o}, 32'h40);
    check("mid_rst_rdata", rsp_rdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    do_read("rd_0020", 13'h0020, 32'hCAFEF00D);

    // Random mixed stream against a byte-masked reference
    for (int i = 0; i < 4; i++) begin
      ref_mem[13'h100 + i] = 32'h01020304 * (i + 1);
      do_write("preload_rand", 13'h100 + 13'(i), ref_mem[13'h100 + i], 4'hF);
    end
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 2);
      a = 13'h100 + 13'($urandom_range(0, 3));
      d = $urandom;
      be = (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
      if (kind == 0) begin
        issue(1'b0, a, 32'h0, 4'h0);
        get_rsp("rand_rd", ref_mem[a], 1, 1'b1);
      end else begin
        exp_d = ref_mem[a];
        for (int b = 0; b < 4; b++)
          if (be[b]) exp_d[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = exp_d;
        issue(1'b1, a, d, be);
        get_rsp("rand_wr", 32'h0, (kind == 1) ? 0 : 1, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++)
      do_read("final_rd", 13'h100 + 13'(i), ref_mem[13'h100 + i]);

    check("no_access_in_rsp", bad_acc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
